// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// The slave side is the arbiter; the master side is the requesters plus the memory.
interface dmem_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  req0, req1, we0, we1,
        input  addr0, addr1, wdata0, wdata1,
        input  mem_rd,
        output gnt0, gnt1, rvalid0, rvalid1,
        output rdata0, rdata1,
        output mem_we, mem_addr, mem_wd
    );

    modport master (
        output req0, req1, we0, we1,
        output addr0, addr1, wdata0, wdata1,
        output mem_rd,
        input  gnt0, gnt1, rvalid0, rvalid1,
        input  rdata0, rdata1,
        input  mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory: bounded bursts,
// alternating priority on contention, read data registered one cycle after grant.
module dmem_arbiter #(
    parameter int DW        = 32,
    parameter int AW        = 5,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          at_max;
    logic          gnt0, gnt1;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [AW-1:0] addr_sel;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt0    = (state_q == OWN0) && bus.req0;
        gnt1    = (state_q == OWN1) && bus.req1;
        cnt_inc = cnt_q + CW'(1);
        at_max  = (cnt_inc == CNT_MAX);
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // On contention the requester that did not own last wins.
                if (bus.req0 && bus.req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (bus.req0) begin
                    state_d = OWN0;
                end else if (bus.req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (gnt0) begin
                    last_d = 1'b0;
                    cnt_d  = at_max ? '0 : cnt_inc;
                    if (at_max && bus.req1) begin
                        state_d = OWN1;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = bus.req1 ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (gnt1) begin
                    last_d = 1'b1;
                    cnt_d  = at_max ? '0 : cnt_inc;
                    if (at_max && bus.req0) begin
                        state_d = OWN0;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = bus.req0 ? OWN0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rvalid0_d = gnt0 && !bus.we0;
        rvalid1_d = gnt1 && !bus.we1;
        rdata0_d  = rvalid0_d ? bus.mem_rd : rdata0_q;
        rdata1_d  = rvalid1_d ? bus.mem_rd : rdata1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // Address/data mux follows the owner; only mem_we is gated by the grant.
    assign addr_sel     = (state_q == OWN1) ? bus.addr1 : bus.addr0;
    assign bus.mem_addr = 32'(addr_sel);
    assign bus.mem_wd   = (state_q == OWN1) ? bus.wdata1 : bus.wdata0;
    assign bus.mem_we   = (gnt0 && bus.we0) || (gnt1 && bus.we1);
    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MB = 4;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    bit   chk_on = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    dmem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    dmem_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT, and the model's own copy of what it must hold.
    logic [DW-1:0] mem     [32];
    logic [DW-1:0] ref_mem [32];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[AW-1:0]] <= bus.mem_wd;
    end
    assign bus.mem_rd = mem[bus.mem_addr[AW-1:0]];

    // Model: who owns the memory (-1 = nobody), beats used, last owner.
    int            m_own   = -1;
    int            m_beats = 0;
    int            m_last  = 1;
    logic          m_rv [2];
    logic [DW-1:0] m_rd [2];

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own   = -1;
        m_beats = 0;
        m_last  = 1;
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = 1'b0;
            m_rd[i] = '0;
        end
    endtask

    task automatic model_step();
        logic          r [2];
        logic          w [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        int            x;
        int            y;
        r[0] = bus.req0;   r[1] = bus.req1;
        w[0] = bus.we0;    w[1] = bus.we1;
        a[0] = bus.addr0;  a[1] = bus.addr1;
        d[0] = bus.wdata0; d[1] = bus.wdata1;
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (m_own < 0) begin
            m_beats = 0;
            if (r[0] && r[1]) m_own = 1 - m_last;
            else if (r[0]) m_own = 0;
            else if (r[1]) m_own = 1;
        end else begin
            x = m_own;
            y = 1 - x;
            if (!r[x]) begin
                m_beats = 0;
                m_own   = r[y] ? y : -1;
            end else begin
                m_last = x;
                m_beats++;
                if (w[x]) begin
                    ref_mem[a[x]] = d[x];
                end else begin
                    m_rd[x] = ref_mem[a[x]];
                    m_rv[x] = 1'b1;
                end
                if (m_beats == MB) begin
                    m_beats = 0;
                    if (r[y]) m_own = y;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) model_reset();
        else model_step();
    end

    task automatic compare();
        logic eg0, eg1, ew;
        eg0 = (m_own == 0) && bus.req0;
        eg1 = (m_own == 1) && bus.req1;
        ew  = (eg0 && bus.we0) || (eg1 && bus.we1);
        chk("gnt0", bus.gnt0, eg0);
        chk("gnt1", bus.gnt1, eg1);
        chk("gnt_excl", bus.gnt0 & bus.gnt1, 0);
        chk("mem_we", bus.mem_we, ew);
        if (eg0) chk("mem_addr0", bus.mem_addr, 32'(bus.addr0));
        if (eg1) chk("mem_addr1", bus.mem_addr, 32'(bus.addr1));
        if (eg0 && bus.we0) chk("mem_wd0", bus.mem_wd, bus.wdata0);
        if (eg1 && bus.we1) chk("mem_wd1", bus.mem_wd, bus.wdata1);
        chk("rvalid0", bus.rvalid0, m_rv[0]);
        chk("rvalid1", bus.rvalid1, m_rv[1]);
        chk("rdata0", bus.rdata0, m_rd[0]);
        chk("rdata1", bus.rdata1, m_rd[1]);
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_on && !reset) compare();
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (n) drive_edge();
    endtask

    initial begin
        logic [DW-1:0] old7;
        logic [8:0]    e0;
        logic [8:0]    e1;
        int            seen [$];
        logic          pg0;
        logic          pg1;

        for (int i = 0; i < 32; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;

        #2 reset = 1'b1;
        drive_edge();
        drive_edge();
        to_neg();
        chk("rst_gnt0", bus.gnt0, 0);
        chk("rst_gnt1", bus.gnt1, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_rvalid0", bus.rvalid0, 0);
        chk("rst_rvalid1", bus.rvalid1, 0);
        chk("rst_rdata0", bus.rdata0, 0);
        chk("rst_rdata1", bus.rdata1, 0);

        // Both request on reset release: one IDLE cycle, then requester 0.
        drive_edge();
        reset  = 1'b0;
        chk_on = 1'b1;
        bus.req0 = 1; bus.req1 = 1;
        bus.addr0 = 5'd1; bus.addr1 = 5'd2;
        to_neg();
        chk("rel_idle0", bus.gnt0, 0);
        chk("rel_idle1", bus.gnt1, 0);
        drive_edge();
        to_neg();
        chk("rel_gnt0", bus.gnt0, 1);
        chk("rel_gnt1", bus.gnt1, 0);
        drive_edge();
        idle(3);

        // Write then read back the same word.
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5'd3;
        bus.wdata0 = 32'hDEADBEEF;
        to_neg();
        chk("wr_idle", bus.gnt0, 0);
        drive_edge();
        to_neg();
        chk("wr_gnt0", bus.gnt0, 1);
        chk("wr_we", bus.mem_we, 1);
        chk("wr_addr", bus.mem_addr, 32'd3);
        chk("wr_wd", bus.mem_wd, 32'hDEADBEEF);
        drive_edge();
        bus.we0 = 0;
        to_neg();
        chk("rd_gnt0", bus.gnt0, 1);
        chk("rd_we", bus.mem_we, 0);
        chk("rd_no_rvalid_wr", bus.rvalid0, 0);
        drive_edge();
        bus.req0 = 0;
        to_neg();
        chk("rd_rvalid0", bus.rvalid0, 1);
        chk("rd_rdata0", bus.rdata0, 32'hDEADBEEF);
        drive_edge();
        to_neg();
        chk("rd_pulse_end", bus.rvalid0, 0);
        chk("rd_hold", bus.rdata0, 32'hDEADBEEF);
        drive_edge();
        idle(2);

        // Burst limit handover: req1 joins at beat 1, takes over at cycle 5.
        e0 = 9'b110011110;
        e1 = 9'b000100000;
        bus.we0 = 0; bus.we1 = 1;
        bus.addr0 = 5'd5; bus.addr1 = 5'd9;
        bus.wdata1 = $urandom;
        bus.req0 = 1;
        for (int c = 0; c < 9; c++) begin
            bus.req1 = (c >= 1 && c <= 5);
            to_neg();
            chk("burst_gnt0", bus.gnt0, e0[c]);
            chk("burst_gnt1", bus.gnt1, e1[c]);
            drive_edge();
        end
        idle(2);

        // Lone requester keeps the memory past MAX_BURST.
        bus.req1 = 1;
        for (int c = 0; c < 11; c++) begin
            bus.we1    = logic'(c % 2);
            bus.addr1  = AW'(c);
            bus.wdata1 = $urandom;
            to_neg();
            chk("solo_gnt1", bus.gnt1, (c >= 1));
            chk("solo_gnt0", bus.gnt0, 0);
            drive_edge();
        end
        idle(2);

        // Each requester drops for a cycle after its beat: grants alternate.
        bus.we0 = 0; bus.we1 = 0;
        pg0 = 0; pg1 = 0;
        for (int c = 0; c < 12; c++) begin
            bus.req0 = !pg0;
            bus.req1 = !pg1;
            to_neg();
            pg0 = bus.gnt0;
            pg1 = bus.gnt1;
            if (bus.gnt0) seen.push_back(0);
            if (bus.gnt1) seen.push_back(1);
            drive_edge();
        end
        for (int i = 0; i < 4; i++) begin
            chk("alt_order", (i < seen.size()) ? 32'(seen[i]) : 32'hFFFF_FFFF,
                32'(i % 2));
        end
        idle(2);

        // Reset lands in the middle of a granted write to word 7.
        old7 = mem[7];
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 5'd7;
        bus.wdata0 = ~old7;
        to_neg();
        drive_edge();
        to_neg();
        chk("mid_gnt0", bus.gnt0, 1);
        chk("mid_we", bus.mem_we, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_we", bus.mem_we, 0);
        chk("async_gnt0", bus.gnt0, 0);
        chk("async_rvalid0", bus.rvalid0, 0);
        chk("async_rvalid1", bus.rvalid1, 0);
        drive_edge();
        chk("rst_no_write", mem[7], old7);
        reset = 1'b0;
        to_neg();
        chk("post_rst_idle", bus.gnt0, 0);
        drive_edge();
        to_neg();
        chk("post_rst_gnt0", bus.gnt0, 1);
        drive_edge();
        idle(2);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset      = ($urandom_range(0, 299) == 0);
            bus.req0   = ($urandom_range(0, 3) != 0);
            bus.req1   = ($urandom_range(0, 3) != 0);
            bus.we0    = 1'($urandom_range(0, 1));
            bus.we1    = 1'($urandom_range(0, 1));
            bus.addr0  = AW'($urandom_range(0, 31));
            bus.addr1  = AW'($urandom_range(0, 31));
            bus.wdata0 = $urandom;
            bus.wdata1 = $urandom;
            drive_edge();
        end
        reset = 1'b0;
        idle(3);

        for (int i = 0; i < 32; i++) begin
            chk("mem_final", mem[i], ref_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, data word width.
REQ-002 SHALL have parameter AW, default 5, word-address width (32 locations).
REQ-003 SHALL have parameter MAX_BURST, default 4, max consecutive beats per owner while the other requester waits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req0/req1  input  1 each  access request, level, held per beat.
REQ-007 SHALL have ports we0/we1  input  1 each  1 = write beat, 0 = read beat.
REQ-008 SHALL have ports addr0/addr1  input  AW each  word address.
REQ-009 SHALL have ports wdata0/wdata1  input  DW each  write data.
REQ-010 SHALL have ports gnt0/gnt1  output  1 each  beat accepted this cycle.
REQ-011 SHALL have ports rvalid0/rvalid1  output  1 each  read data valid, one-cycle pulse.
REQ-012 SHALL have ports rdata0/rdata1  output  DW each  registered read data.
REQ-013 SHALL have port mem_we  output  1  write enable to data memory.
REQ-014 SHALL have port mem_addr  output  32  memory address, addr zero-extended.
REQ-015 SHALL have port mem_wd  output  DW  memory write data.
REQ-016 SHALL have port mem_rd  input  DW  combinational memory read data.

Function
REQ-017 SHALL implement FSM states IDLE, OWN0, OWN1, plus 1-bit last-owner pointer and beat counter (0..MAX_BURST).
REQ-018 SHALL, in IDLE, assert no grant; next edge: only reqX -> OWNX; both -> OWN of requester not equal to last-owner; none -> IDLE.
REQ-019 SHALL drive gntX = (state==OWNX) & reqX, combinational.
REQ-020 SHALL, when gntX=1, drive mem_we=weX, mem_addr={0,addrX}, mem_wd=wdataX; otherwise mem_we=0, mem_addr/mem_wd hold the OWN requester's values (don't care, but mem_we strictly 0).
REQ-021 SHALL increment beat counter on each granted beat; set last-owner=X on each granted beat.
REQ-022 SHALL leave OWNX when reqX=0: to OWNY if reqY=1, else IDLE; counter cleared.
REQ-023 SHALL, on the granted beat that brings the counter to MAX_BURST with reqY=1, move to OWNY next cycle, counter cleared.
REQ-024 SHALL, at MAX_BURST with reqY=0, stay in OWNX and clear counter (no forced release).
REQ-025 SHALL, on a granted read beat, capture mem_rd into rdataX and pulse rvalidX exactly one cycle later; rdataX holds value until next read for X.
REQ-026 SHALL never assert gnt0 and gnt1 in the same cycle; never assert rvalid for a write beat.
REQ-027 SHALL give no wasted cycle on handover OWNX->OWNY; IDLE->OWN costs one cycle of latency.
REQ-028 SHALL treat a write followed immediately by a read to the same address as returning the new data (memory write on edge, read next cycle).

Reset
REQ-029 SHALL, while reset=1 (asynchronously), force state=IDLE, last-owner=1 (requester 0 favoured first), counter=0, rvalid0/1=0, rdata0/1=0, hence gnt0/1=0 and mem_we=0 immediately.
REQ-030 SHALL abort any burst on reset without performing the pending beat; first grant after release needs a full IDLE cycle.

Verification
REQ-031 Reset release, req0=req1=1 same cycle -> IDLE one cycle, then gnt0=1 (pointer favours 0).
REQ-032 req0 only, write addr0=3, wdata0=0xDEADBEEF, then read addr0=3 -> mem_we=1 at 3, rvalid0 pulse one cycle after read beat with rdata0=0xDEADBEEF.
REQ-033 req0 held 6 beats, req1 raised at beat 1 -> gnt0 for 4 beats, gnt1 starting cycle 5 with no gap, gnt0 never concurrent.
REQ-034 req1 alone held 10 beats, MAX_BURST=4 -> gnt1 continuous 10 cycles, no release.
REQ-035 reset asserted mid-burst on granted write to addr 7 -> mem_we drops same cycle, addr 7 unchanged, rvalid0/1=0.
REQ-036 alternating single-beat requests, both continuously asserted with deasserts after each beat -> grants alternate 0,1,0,1.
